// File: rtl/tdm_mac_pkg.sv
// rtl/tdm_mac_pkg.sv - shared state encoding and multiplier sizing helper for tdm_mac
package tdm_mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } tdm_state_t;

  // Bits of the multiplier operand consumed per cycle for each inner multiplier kind.
  function automatic int mul_digit_bits(input int mul_type);
    if (mul_type <= 1) begin
      return 1;
    end else if (mul_type == 2) begin
      return 2;
    end else begin
      return 4;
    end
  endfunction

endpackage

// File: rtl/tdm_mac_mul.sv
// rtl/tdm_mac_mul.sv - iterative fixed-point multiplier, result = (a*b) >> FIXED_POINT truncated
module tdm_mac_mul
  import tdm_mac_pkg::*;
#(
  parameter int C_WIDTH     = 32,
  parameter int FIXED_POINT = 8,
  parameter int MUL_TYPE    = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_trigger,
  input  logic               i_signed,
  input  logic [C_WIDTH-1:0] i_a,
  input  logic [C_WIDTH-1:0] i_b,
  output logic               o_ready,
  output logic               o_done,
  output logic [C_WIDTH-1:0] o_result
);

  localparam int DIGIT = mul_digit_bits(MUL_TYPE);
  localparam int STEPS = C_WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PW    = C_WIDTH + FIXED_POINT;

  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_cnt;
  logic [PW-1:0]      r_acc;
  logic [PW-1:0]      r_mcand;
  logic [C_WIDTH-1:0] r_mplier;

  logic [PW-1:0]      w_mcand_init;
  logic [PW-1:0]      w_acc_init;
  logic [PW-1:0]      w_partial;
  logic               w_unused_acc;

  // Only the low PW product bits are ever kept; a negative signed b is handled by
  // pre-loading -(a << C_WIDTH) and then treating b's bits as unsigned digits.
  assign w_mcand_init = i_signed ? {{FIXED_POINT{i_a[C_WIDTH-1]}}, i_a}
                                 : {{FIXED_POINT{1'b0}}, i_a};
  assign w_acc_init   = (i_signed && i_b[C_WIDTH-1])
                      ? ({PW{1'b0}} - {i_a[FIXED_POINT-1:0], {C_WIDTH{1'b0}}})
                      : {PW{1'b0}};
  assign w_partial    = r_mcand * PW'(r_mplier[DIGIT-1:0]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_acc    <= r_acc + w_partial;
        r_mcand  <= r_mcand << DIGIT;
        r_mplier <= r_mplier >> DIGIT;
        if (r_cnt == CNT_W'(STEPS - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (i_trigger) begin
        r_acc    <= w_acc_init;
        r_mcand  <= w_mcand_init;
        r_mplier <= i_b;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end
    end
  end

  assign o_ready      = !r_busy;
  assign o_done       = r_done;
  assign o_result     = r_acc[PW-1:FIXED_POINT];
  assign w_unused_acc = ^r_acc[FIXED_POINT-1:0];

endmodule

// File: rtl/tdm_mac_sat_acc.sv
// rtl/tdm_mac_sat_acc.sv - combinational accumulate/replace with signed or unsigned saturation
module tdm_mac_sat_acc #(
  parameter int C_WIDTH = 32
) (
  input  logic [C_WIDTH-1:0] i_y,
  input  logic [C_WIDTH-1:0] i_p,
  input  logic               i_acc,
  input  logic               i_signed,
  output logic [C_WIDTH-1:0] o_next_y,
  output logic               o_sat
);

  logic [C_WIDTH:0] w_ext_y;
  logic [C_WIDTH:0] w_ext_p;
  logic [C_WIDTH:0] w_sum;

  assign w_ext_y = {i_signed & i_y[C_WIDTH-1], i_y};
  assign w_ext_p = {i_signed & i_p[C_WIDTH-1], i_p};
  assign w_sum   = w_ext_y + w_ext_p;

  always_comb begin
    o_next_y = i_p;
    o_sat    = 1'b0;
    if (i_acc) begin
      o_next_y = w_sum[C_WIDTH-1:0];
      if (i_signed) begin
        // Top two bits of the extended sum disagree only on two's-complement overflow.
        if (w_sum[C_WIDTH] != w_sum[C_WIDTH-1]) begin
          o_sat    = 1'b1;
          o_next_y = w_sum[C_WIDTH] ? {1'b1, {(C_WIDTH-1){1'b0}}}
                                    : {1'b0, {(C_WIDTH-1){1'b1}}};
        end
      end else if (w_sum[C_WIDTH]) begin
        o_sat    = 1'b1;
        o_next_y = {C_WIDTH{1'b1}};
      end
    end
  end

endmodule

// File: rtl/tdm_mac.sv
// rtl/tdm_mac.sv - frame-driven TDM multiply/MAC engine sharing one multiplier across channels
module tdm_mac
  import tdm_mac_pkg::*;
#(
  parameter int C_WIDTH     = 32,
  parameter int FIXED_POINT = 8,
  parameter int MUL_TYPE    = 3,
  parameter int NUM_UNITS   = 32
) (
  input  logic                         ctl_clk,
  input  logic                         ctl_rst,
  input  logic                         start,
  input  logic                         signed_cal,
  input  logic [NUM_UNITS-1:0]         chan_en,
  input  logic [NUM_UNITS-1:0]         acc_mode,
  input  logic                         acc_clr,
  input  logic [C_WIDTH*NUM_UNITS-1:0] multiplicands,
  input  logic [C_WIDTH*NUM_UNITS-1:0] multipliers,
  output logic [C_WIDTH*NUM_UNITS-1:0] products,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun,
  output logic [NUM_UNITS-1:0]         sat_flag
);

  localparam int IDX_WIDTH = $clog2(NUM_UNITS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_UNITS - 1);

  tdm_state_t         r_state;
  tdm_state_t         w_state_next;
  logic [IDX_WIDTH-1:0] r_idx;
  logic [NUM_UNITS-1:0] r_en;
  logic [NUM_UNITS-1:0] r_acc_mode;
  logic [NUM_UNITS-1:0] r_sat;
  logic                 r_signed;
  logic                 r_overrun;
  logic [C_WIDTH-1:0]   r_a    [NUM_UNITS];
  logic [C_WIDTH-1:0]   r_b    [NUM_UNITS];
  logic [C_WIDTH-1:0]   r_prod [NUM_UNITS];
  logic [C_WIDTH-1:0]   r_result;

  logic                 w_last;
  logic                 w_en_cur;
  logic                 w_trigger;
  logic                 w_mul_ready;
  logic                 w_mul_done;
  logic [C_WIDTH-1:0]   w_mul_result;
  logic [C_WIDTH-1:0]   w_next_y;
  logic                 w_sat;

  assign w_last   = (r_idx == LAST_IDX);
  assign w_en_cur = r_en[r_idx];

  tdm_mac_mul #(
    .C_WIDTH    (C_WIDTH),
    .FIXED_POINT(FIXED_POINT),
    .MUL_TYPE   (MUL_TYPE)
  ) u_mul (
    .i_clk    (ctl_clk),
    .i_rst_n  (ctl_rst),
    .i_trigger(w_trigger),
    .i_signed (r_signed),
    .i_a      (r_a[r_idx]),
    .i_b      (r_b[r_idx]),
    .o_ready  (w_mul_ready),
    .o_done   (w_mul_done),
    .o_result (w_mul_result)
  );

  tdm_mac_sat_acc #(
    .C_WIDTH(C_WIDTH)
  ) u_sat_acc (
    .i_y     (r_prod[r_idx]),
    .i_p     (r_result),
    .i_acc   (r_acc_mode[r_idx]),
    .i_signed(r_signed),
    .o_next_y(w_next_y),
    .o_sat   (w_sat)
  );

  always_ff @(posedge ctl_clk or negedge ctl_rst) begin
    if (!ctl_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_trigger    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!w_en_cur) begin
          w_state_next = w_last ? ST_DONE : ST_ISSUE;
        end else if (w_mul_ready) begin
          w_trigger    = 1'b1;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_mul_done) begin
          w_state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_state_next = w_last ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ctl_clk or negedge ctl_rst) begin
    if (!ctl_rst) begin
      r_idx      <= '0;
      r_en       <= '0;
      r_acc_mode <= '0;
      r_sat      <= '0;
      r_signed   <= 1'b0;
      r_overrun  <= 1'b0;
      r_result   <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        r_a[i]    <= '0;
        r_b[i]    <= '0;
        r_prod[i] <= '0;
      end
    end else begin
      r_overrun <= start && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx      <= '0;
            r_en       <= chan_en;
            r_acc_mode <= acc_mode;
            r_signed   <= signed_cal;
            r_sat      <= '0;
            for (int i = 0; i < NUM_UNITS; i++) begin
              r_a[i] <= multiplicands[i*C_WIDTH +: C_WIDTH];
              r_b[i] <= multipliers[i*C_WIDTH +: C_WIDTH];
            end
          end else if (acc_clr) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
              r_prod[i] <= '0;
            end
          end
        end
        ST_ISSUE: begin
          if (!w_en_cur && !w_last) begin
            r_idx <= r_idx + IDX_WIDTH'(1);
          end
        end
        ST_WAIT: begin
          if (w_mul_done) begin
            r_result <= w_mul_result;
          end
        end
        ST_WRITE: begin
          r_prod[r_idx] <= w_next_y;
          if (w_sat) begin
            r_sat[r_idx] <= 1'b1;
          end
          if (!w_last) begin
            r_idx <= r_idx + IDX_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_pack
    assign products[g*C_WIDTH +: C_WIDTH] = r_prod[g];
  end

  assign busy       = (r_state != ST_IDLE);
  assign frame_done = (r_state == ST_DONE);
  assign overrun    = r_overrun;
  assign sat_flag   = r_sat;

endmodule

// File: tb/tb_tdm_mac.sv
// tb/tb_tdm_mac.sv - directed vector bench for tdm_mac with 4 channels, Q24.8
module tb_tdm_mac;

  localparam int N = 4;
  localparam int W = 32;

  logic           ctl_clk = 1'b0;
  logic           ctl_rst;
  logic           start;
  logic           signed_cal;
  logic [N-1:0]   chan_en;
  logic [N-1:0]   acc_mode;
  logic           acc_clr;
  logic [W*N-1:0] multiplicands;
  logic [W*N-1:0] multipliers;
  logic [W*N-1:0] products;
  logic           busy;
  logic           frame_done;
  logic           overrun;
  logic [N-1:0]   sat_flag;

  tdm_mac #(
    .C_WIDTH    (W),
    .FIXED_POINT(8),
    .MUL_TYPE   (3),
    .NUM_UNITS  (N)
  ) dut (
    .ctl_clk      (ctl_clk),
    .ctl_rst      (ctl_rst),
    .start        (start),
    .signed_cal   (signed_cal),
    .chan_en      (chan_en),
    .acc_mode     (acc_mode),
    .acc_clr      (acc_clr),
    .multiplicands(multiplicands),
    .multipliers  (multipliers),
    .products     (products),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun),
    .sat_flag     (sat_flag)
  );

  always #5 ctl_clk = ~ctl_clk;

  typedef struct {
    logic [3:0]   en;
    logic [3:0]   acc;
    logic         sgn;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] exp_p;
    logic [3:0]   exp_sat;
    int           exp_lat;
  } vec_t;

  vec_t tv [8];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [3:0] en, input logic [3:0] acc, input logic sgn,
                           input logic [127:0] a, input logic [127:0] b, input int ovr_at,
                           output int n_done, output int lat);
    int  cyc;
    bit  fin;
    @(negedge ctl_clk);
    chan_en = en; acc_mode = acc; signed_cal = sgn;
    multiplicands = a; multipliers = b; start = 1'b1;
    @(negedge ctl_clk);
    start = 1'b0;
    multiplicands = ~a; multipliers = ~b; chan_en = ~en; acc_mode = ~acc; signed_cal = ~sgn;
    n_done = 0; lat = -1; cyc = 1; fin = 0;
    while (!fin && cyc < 3000) begin
      if (frame_done) begin
        n_done++;
        if (lat < 0) lat = cyc;
      end
      if (n_done > 0 && !frame_done && !busy) begin
        fin = 1;
      end else begin
        if (ovr_at > 0 && cyc == ovr_at) start = 1'b1;
        if (ovr_at > 0 && cyc == ovr_at + 1) begin
          start = 1'b0;
          chk("overrun_pulse", overrun, 1);
        end
        if (ovr_at > 0 && cyc == ovr_at + 2) chk("overrun_single", overrun, 0);
        @(negedge ctl_clk);
        cyc++;
      end
    end
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: got busy=%0b after %0d cycles, required frame completion", busy, cyc);
    end
  endtask

  initial begin
    int nd;
    int lat;
    ctl_rst = 1'b0; start = 1'b0; signed_cal = 1'b0; chan_en = '0; acc_mode = '0;
    acc_clr = 1'b0; multiplicands = '0; multipliers = '0;

    tv[0] = '{4'hF, 4'h0, 1'b1,
              {32'h00000100, 32'h7FFFFF00, 32'hFFFFFE00, 32'h00000200},
              {32'h00000100, 32'h00000100, 32'h00000180, 32'h00000180},
              {32'h00000100, 32'h7FFFFF00, 32'hFFFFFD00, 32'h00000300}, 4'h0, 0};
    tv[1] = '{4'hF, 4'h0, 1'b0,
              {32'hFFFFFFFF, 32'h7FFFFF00, 32'h00000200, 32'hFFFFFE00},
              {32'hFFFFFFFF, 32'h00000100, 32'h00000180, 32'h00000180},
              {32'hFE000000, 32'h7FFFFF00, 32'h00000300, 32'h7FFFFD00}, 4'h0, 0};
    tv[2] = '{4'hF, 4'b0100, 1'b1,
              {32'h00000000, 32'h00000300, 32'hFFFFFE00, 32'h00000200},
              {32'h00000005, 32'h00000100, 32'hFFFFFE00, 32'h00000180},
              {32'h00000000, 32'h7FFFFFFF, 32'h00000400, 32'h00000300}, 4'b0100, 0};
    tv[3] = '{4'hF, 4'b1011, 1'b1,
              {32'hFFFFFE00, 32'h00000200, 32'hFFFFFF00, 32'h00000100},
              {32'h00000180, 32'h00000200, 32'h00000800, 32'h00000100},
              {32'hFFFFFD00, 32'h00000400, 32'hFFFFFC00, 32'h00000400}, 4'h0, 0};
    tv[4] = '{4'b1000, 4'h0, 1'b1,
              {32'h80000100, 32'h12345678, 32'h12345678, 32'h12345678},
              {32'h00000100, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'h9ABCDEF0},
              {32'h80000100, 32'h00000400, 32'hFFFFFC00, 32'h00000400}, 4'h0, 0};
    tv[5] = '{4'b1001, 4'b1001, 1'b1,
              {32'hFFFFFE00, 32'h12345678, 32'h12345678, 32'h00000100},
              {32'h00000100, 32'h00001111, 32'h00001111, 32'h00000200},
              {32'h80000000, 32'h00000400, 32'hFFFFFC00, 32'h00000600}, 4'b1000, 0};
    tv[6] = '{4'b0101, 4'b0101, 1'b0,
              {32'h00000001, 32'h00000200, 32'h00000001, 32'hFFFFFF00},
              {32'h00000001, 32'h00000100, 32'h00000001, 32'h00000100},
              {32'h80000000, 32'h00000600, 32'hFFFFFC00, 32'hFFFFFFFF}, 4'b0001, 0};
    tv[7] = '{4'h0, 4'hF, 1'b1, 128'h0, 128'h0,
              {32'h80000000, 32'h00000600, 32'hFFFFFC00, 32'hFFFFFFFF}, 4'h0, 5};

    repeat (3) @(negedge ctl_clk);
    chk("reset_products", products, 0);
    chk("reset_status", {busy, frame_done, overrun, sat_flag}, 0);
    ctl_rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_frame(tv[i].en, tv[i].acc, tv[i].sgn, tv[i].a, tv[i].b, 0, nd, lat);
      chk($sformatf("vec%0d_products", i), products, tv[i].exp_p);
      chk($sformatf("vec%0d_sat_flag", i), sat_flag, tv[i].exp_sat);
      chk($sformatf("vec%0d_done_count", i), nd, 1);
      if (tv[i].exp_lat > 0) chk($sformatf("vec%0d_latency", i), lat, tv[i].exp_lat);
    end

    run_frame(tv[0].en, tv[0].acc, tv[0].sgn, tv[0].a, tv[0].b, 3, nd, lat);
    chk("overrun_products", products, tv[0].exp_p);
    chk("overrun_done_count", nd, 1);

    @(negedge ctl_clk);
    chan_en = '0; start = 1'b1; acc_clr = 1'b1;
    @(negedge ctl_clk);
    start = 1'b0; acc_clr = 1'b0;
    repeat (8) @(negedge ctl_clk);
    chk("clr_with_start_ignored", products, tv[0].exp_p);
    chk("clr_with_start_idle", busy, 0);
    acc_clr = 1'b1;
    @(negedge ctl_clk);
    acc_clr = 1'b0;
    chk("acc_clr_products", products, 0);

    run_frame(tv[0].en, tv[0].acc, tv[0].sgn, tv[0].a, tv[0].b, 0, nd, lat);
    chk("pre_reset_products", products, tv[0].exp_p);
    @(negedge ctl_clk);
    chan_en = 4'hF; acc_mode = '0; signed_cal = 1'b0;
    multiplicands = tv[1].a; multipliers = tv[1].b; start = 1'b1;
    @(negedge ctl_clk);
    start = 1'b0;
    @(negedge ctl_clk);
    start = 1'b1;
    @(negedge ctl_clk);
    start = 1'b0;
    chk("mid_wait_busy", busy, 1);
    chk("mid_wait_overrun", overrun, 1);
    ctl_rst = 1'b0;
    #1;
    chk("async_reset_products", products, 0);
    chk("async_reset_status", {busy, frame_done, overrun, sat_flag}, 0);
    repeat (2) @(negedge ctl_clk);
    ctl_rst = 1'b1;

    run_frame(tv[1].en, tv[1].acc, tv[1].sgn, tv[1].a, tv[1].b, 0, nd, lat);
    chk("post_reset_products", products, tv[1].exp_p);
    chk("post_reset_done_count", nd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
